// File: rtl/led_string_encoder.sv
// WS2812-class one-wire encoder: serialises 24-bit pixels MSB first as NRZ high/low
// pulses on sdi and closes each frame with a long low latch period.
module led_string_encoder #(
    parameter int T0H_CYCLES   = 8,
    parameter int T1H_CYCLES   = 16,
    parameter int BIT_CYCLES   = 25,
    parameter int LATCH_CYCLES = 6000,
    parameter int PIXEL_BITS   = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PIXEL_BITS-1:0] pixel_data,
    input  logic                  pixel_valid,
    input  logic                  pixel_last,
    output logic                  pixel_ready,
    output logic                  sdi,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  underrun
);

    // state    | meaning
    // ST_IDLE  | no frame open
    // ST_SHIFT | transmitting a pixel
    // ST_WAIT  | frame open, no data yet, sdi low
    // ST_LATCH | frame closed, holding sdi low
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_WAIT, ST_LATCH} state_t;

    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BIT_W = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;
    localparam int LAT_W = $clog2(LATCH_CYCLES + 1);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] T0H_C    = CYC_W'(T0H_CYCLES);
    localparam logic [CYC_W-1:0] T1H_C    = CYC_W'(T1H_CYCLES);
    localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(PIXEL_BITS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

    if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES &&
          T1H_CYCLES < BIT_CYCLES && LATCH_CYCLES >= 2)) begin : g_param_check
        $error("led_string_encoder: illegal timing parameters");
    end

    state_t                 state_q, state_d;
    logic [CYC_W-1:0]       cyc_q, cyc_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [LAT_W-1:0]       lat_q, lat_d;
    logic [PIXEL_BITS-1:0]  data_q, data_d;
    logic                   last_q, last_d;
    logic                   sdi_q, sdi_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   urun_q, urun_d;
    logic                   accept;

    assign accept = pixel_valid && ready_q;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        lat_d   = lat_q;
        data_d  = data_q;
        last_d  = last_q;
        done_d  = 1'b0;
        urun_d  = 1'b0;

        case (state_q)
            ST_IDLE: ;
            ST_SHIFT: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (bit_q == '0) begin
                        // a pixel offered at the boundary wins over closing the frame
                        if (!accept) begin
                            state_d = last_q ? ST_LATCH : ST_WAIT;
                            lat_d   = '0;
                        end
                    end else begin
                        bit_d = bit_q - 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (!accept) begin
                    if (lat_q == LAT_LAST) begin
                        state_d = ST_IDLE;
                        urun_d  = 1'b1;
                        lat_d   = '0;
                    end else begin
                        lat_d = lat_q + 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                if (lat_q == LAT_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    lat_d   = '0;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // ready_q is only ever high in IDLE, WAIT or the final cycle of a pixel
        if (accept) begin
            state_d = ST_SHIFT;
            data_d  = pixel_data;
            last_d  = pixel_last;
            cyc_d   = '0;
            bit_d   = BIT_TOP;
            lat_d   = '0;
        end

        sdi_d   = (state_d == ST_SHIFT) && (cyc_d < (data_d[bit_d] ? T1H_C : T0H_C));
        ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT) ||
                  ((state_d == ST_SHIFT) && (cyc_d == CYC_LAST) && (bit_d == '0));
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            lat_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            sdi_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            urun_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
            last_q  <= last_d;
            sdi_q   <= sdi_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            urun_q  <= urun_d;
        end
    end

    assign sdi         = sdi_q;
    assign pixel_ready = ready_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign underrun    = urun_q;

endmodule

// File: tb/tb_led_string_encoder.sv
// Directed bench for led_string_encoder: default-timing instance plus a short-latch
// instance sharing one stimulus; o_* selects which instance is being observed.
module tb_led_string_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        pix_last = 1'b0;
    logic        sel = 1'b0;

    logic d_ready, d_sdi, d_busy, d_fd, d_ur;
    logic s_ready, s_sdi, s_busy, s_fd, s_ur;
    logic o_ready, o_sdi, o_busy, o_fd, o_ur;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    led_string_encoder u_dut (
        .clk(clk), .reset_n(reset_n), .pixel_data(pix_data), .pixel_valid(pix_valid),
        .pixel_last(pix_last), .pixel_ready(d_ready), .sdi(d_sdi), .busy(d_busy),
        .frame_done(d_fd), .underrun(d_ur)
    );

    led_string_encoder #(.LATCH_CYCLES(100)) u_dut_s (
        .clk(clk), .reset_n(reset_n), .pixel_data(pix_data), .pixel_valid(pix_valid),
        .pixel_last(pix_last), .pixel_ready(s_ready), .sdi(s_sdi), .busy(s_busy),
        .frame_done(s_fd), .underrun(s_ur)
    );

    assign o_ready = sel ? s_ready : d_ready;
    assign o_sdi   = sel ? s_sdi   : d_sdi;
    assign o_busy  = sel ? s_busy  : d_busy;
    assign o_fd    = sel ? s_fd    : d_fd;
    assign o_ur    = sel ? s_ur    : d_ur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observes one 600-cycle pixel starting the cycle after its accept edge.
    // The next stimulus (nv/nd/nl) is applied right after the first sample.
    task automatic watch_pixel(input string tag, input logic [23:0] px,
                               input logic nv, input logic [23:0] nd, input logic nl);
        logic [24:0] got, exp;
        int bad_rdy, bad_busy;
        bad_rdy = 0;
        bad_busy = 0;
        for (int b = 23; b >= 0; b--) begin
            got = '0;
            exp = '0;
            for (int c = 0; c < 25; c++) begin
                @(negedge clk);
                got[c] = o_sdi;
                exp[c] = (c < (px[b] ? 16 : 8));
                if (o_ready !== ((b == 0 && c == 24) ? 1'b1 : 1'b0)) bad_rdy++;
                if (o_busy !== 1'b1) bad_busy++;
                if (b == 23 && c == 0) begin
                    pix_valid = nv;
                    pix_data  = nd;
                    pix_last  = nl;
                end
            end
            chk($sformatf("%s_bit%0d", tag, b), 32'(got), 32'(exp));
        end
        chk({tag, "_ready_pattern"}, 32'(bad_rdy), 32'd0);
        chk({tag, "_busy"}, 32'(bad_busy), 32'd0);
    endtask

    // Observes n low cycles (LATCH when exp_fd, else WAIT) then the terminating pulse.
    task automatic watch_end(input string tag, input int n, input logic exp_fd,
                             input logic nv, input logic [23:0] nd, input logic nl);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_sdi !== 1'b0 || o_fd !== 1'b0 || o_ur !== 1'b0 || o_busy !== 1'b1 ||
                o_ready !== !exp_fd) bad++;
            if (i == 0) begin
                pix_valid = nv;
                pix_data  = nd;
                pix_last  = nl;
            end
        end
        chk({tag, "_low_phase"}, 32'(bad), 32'd0);
        @(negedge clk);
        chk({tag, "_frame_done"}, 32'(o_fd), 32'(exp_fd));
        chk({tag, "_underrun"}, 32'(o_ur), 32'(!exp_fd));
        chk({tag, "_busy_end"}, 32'(o_busy), 32'd0);
        chk({tag, "_ready_end"}, 32'(o_ready), 32'd1);
        chk({tag, "_sdi_end"}, 32'(o_sdi), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        pix_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_ready_before_edge", 32'(o_ready), 32'd0);
        @(negedge clk);
        chk("rst_ready_after_edge", 32'(o_ready), 32'd1);
        chk("rst_busy_after_edge", 32'(o_busy), 32'd0);
    endtask

    initial begin
        int bad;
        // reset values while reset_n is held low
        repeat (2) @(negedge clk);
        chk("rst_sdi", 32'(d_sdi), 32'd0);
        chk("rst_ready", 32'(d_ready), 32'd0);
        chk("rst_busy", 32'(d_busy), 32'd0);
        chk("rst_frame_done", 32'(d_fd), 32'd0);
        chk("rst_underrun", 32'(d_ur), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rst_ready_before_edge", 32'(d_ready), 32'd0);
        @(negedge clk);
        chk("rst_ready_after_edge", 32'(d_ready), 32'd1);

        // single-pixel frame, then valid held through LATCH (accepted only at frame_done)
        sel = 1'b0;
        pix_valid = 1'b1; pix_data = 24'hA5F00F; pix_last = 1'b1;
        watch_pixel("t1", 24'hA5F00F, 1'b0, 24'h0, 1'b0);
        watch_end("t1", 6000, 1'b1, 1'b1, 24'hFFFFFF, 1'b0);

        // back-to-back pixels with valid held; first pixel accepted on the frame_done cycle
        watch_pixel("t2a", 24'hFFFFFF, 1'b1, 24'h000000, 1'b1);
        watch_pixel("t2b", 24'h000000, 1'b0, 24'h0, 1'b0);
        watch_end("t2", 6000, 1'b1, 1'b0, 24'h0, 1'b0);

        // WAIT gap of 40 cycles then the final pixel (short-latch instance)
        sel = 1'b1;
        do_reset();
        pix_valid = 1'b1; pix_data = 24'h123456; pix_last = 1'b0;
        watch_pixel("t3a", 24'h123456, 1'b0, 24'h0, 1'b0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_sdi !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b1 || o_ur !== 1'b0) bad++;
            if (i == 39) begin
                pix_valid = 1'b1; pix_data = 24'h800000; pix_last = 1'b1;
            end
        end
        chk("t3_wait_phase", 32'(bad), 32'd0);
        watch_pixel("t3b", 24'h800000, 1'b0, 24'h0, 1'b0);
        watch_end("t3", 100, 1'b1, 1'b0, 24'h0, 1'b0);

        // underrun: non-last pixel then no data
        pix_valid = 1'b1; pix_data = 24'h00FF00; pix_last = 1'b0;
        watch_pixel("t4", 24'h00FF00, 1'b0, 24'h0, 1'b0);
        watch_end("t4", 100, 1'b0, 1'b0, 24'h0, 1'b0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_fd !== 1'b0 || o_ur !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) bad++;
        end
        chk("t4_idle_after_underrun", 32'(bad), 32'd0);

        // asynchronous reset during the high phase of bit 10
        sel = 1'b0;
        do_reset();
        pix_valid = 1'b1; pix_data = 24'h5A5A5A; pix_last = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        repeat (13 * 25 + 2) @(negedge clk);
        chk("t6_sdi_high_bit10", 32'(o_sdi), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_sdi_async_low", 32'(o_sdi), 32'd0);
        chk("t6_busy_async_low", 32'(o_busy), 32'd0);
        chk("t6_ready_in_reset", 32'(o_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("t6_ready_before_edge", 32'(o_ready), 32'd0);
        @(negedge clk);
        chk("t6_ready_after_edge", 32'(o_ready), 32'd1);
        chk("t6_busy_after_edge", 32'(o_busy), 32'd0);
        pix_valid = 1'b1; pix_data = 24'h800000; pix_last = 1'b1;
        watch_pixel("t6", 24'h800000, 1'b0, 24'h0, 1'b0);
        watch_end("t6", 6000, 1'b1, 1'b0, 24'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
